// File: rtl/node_ingress.sv
// node_ingress: per-node ingress queue with destination filtering, overflow drop and head-of-line stall detection
module node_ingress #(
    parameter int NODE_ID     = 0,
    parameter int NUM_NODES   = 6,
    parameter int DEPTH       = 4,
    parameter int STALL_LIMIT = 16
) (
    input  logic                         clk,
    input  logic                         rst_b,
    input  logic [31:0]                  pkt_in,
    input  logic                         pkt_in_avail,
    output logic [31:0]                  fwd_pkt,
    output logic                         fwd_valid,
    input  logic                         fwd_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [7:0]                   drop_bad_cnt,
    output logic [7:0]                   drop_ovf_cnt,
    output logic                         stall
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(STALL_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, STALLED} stall_state_e;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [OW-1:0] occ_q;
    logic [7:0]    bad_q, ovf_q;
    stall_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          bad_dest, full, pop, push, ovf_drop, blocked;

    assign bad_dest     = {28'd0, pkt_in[27:24]} >= NUM_NODES;
    assign full         = occ_q == OW'(DEPTH);
    assign fwd_valid    = occ_q != '0;
    assign fwd_pkt      = fwd_valid ? mem_q[rptr_q] : 32'h0;
    assign pop          = fwd_valid && fwd_ready;
    // A full queue still accepts when the head leaves on the same edge.
    assign push         = pkt_in_avail && !bad_dest && (!full || pop);
    assign ovf_drop     = pkt_in_avail && !bad_dest && full && !pop;
    assign blocked      = fwd_valid && !fwd_ready;
    assign occupancy    = occ_q;
    assign drop_bad_cnt = bad_q;
    assign drop_ovf_cnt = ovf_q;
    assign stall        = state_q == STALLED;

    // Queue storage and pointers; occupancy kept separately so full/empty never alias.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= {4'(NODE_ID), pkt_in[27:0]};
                wptr_q        <= wptr_q + AW'(1);
            end
            if (pop) rptr_q <= rptr_q + AW'(1);
            occ_q <= occ_q + OW'(push) - OW'(pop);
        end
    end

    // Saturating drop counters for bad destinations and overflow.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            bad_q <= '0;
            ovf_q <= '0;
        end else begin
            if (pkt_in_avail && bad_dest && bad_q != 8'hFF) bad_q <= bad_q + 8'd1;
            if (ovf_drop && ovf_q != 8'hFF) ovf_q <= ovf_q + 8'd1;
        end
    end

    // Stall FSM state register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Count consecutive blocked cycles; saturate so a long block stays STALLED.
    always_comb begin
        state_d = IDLE;
        cnt_d   = '0;
        cnt_inc = (cnt_q >= CW'(STALL_LIMIT)) ? cnt_q : cnt_q + CW'(1);
        if (blocked) begin
            cnt_d   = cnt_inc;
            state_d = (cnt_inc >= CW'(STALL_LIMIT)) ? STALLED : WAIT;
        end
    end
endmodule

// File: tb/tb_node_ingress.sv
// tb_node_ingress: scoreboard bench for node_ingress (NODE_ID=3, DEPTH=4, STALL_LIMIT=16)
module tb_node_ingress;
    logic        clk = 0;
    logic        rst_b = 0;
    logic [31:0] pkt_in = 0;
    logic        pkt_in_avail = 0;
    logic [31:0] fwd_pkt;
    logic        fwd_valid;
    logic        fwd_ready = 0;
    logic [2:0]  occupancy;
    logic [7:0]  drop_bad_cnt, drop_ovf_cnt;
    logic        stall;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    int exp_bad = 0;
    int exp_ovf = 0;
    int blk = 0;
    logic exp_stall = 0;

    node_ingress #(.NODE_ID(3), .NUM_NODES(6), .DEPTH(4), .STALL_LIMIT(16)) dut (
        .clk(clk), .rst_b(rst_b), .pkt_in(pkt_in), .pkt_in_avail(pkt_in_avail),
        .fwd_pkt(fwd_pkt), .fwd_valid(fwd_valid), .fwd_ready(fwd_ready),
        .occupancy(occupancy), .drop_bad_cnt(drop_bad_cnt), .drop_ovf_cnt(drop_ovf_cnt),
        .stall(stall)
    );

    always #5 clk = ~clk;

    // Compare outputs with the model, predict the coming edge, then advance to 1ns past it.
    task automatic tick();
        logic vld;
        vld = exp_q.size() != 0;
        checks++;
        if (fwd_valid !== vld) begin errors++; $display("FAIL fwd_valid got %b exp %b t=%0t", fwd_valid, vld, $time); end
        checks++;
        if (occupancy !== 3'(exp_q.size())) begin errors++; $display("FAIL occupancy got %0d exp %0d t=%0t", occupancy, exp_q.size(), $time); end
        checks++;
        if (stall !== exp_stall) begin errors++; $display("FAIL stall got %b exp %b t=%0t", stall, exp_stall, $time); end
        checks++;
        if (drop_bad_cnt !== 8'(exp_bad) || drop_ovf_cnt !== 8'(exp_ovf)) begin
            errors++; $display("FAIL drop_cnts got %0d/%0d exp %0d/%0d t=%0t", drop_bad_cnt, drop_ovf_cnt, exp_bad, exp_ovf, $time);
        end
        if (vld && fwd_ready) begin
            checks++;
            if (fwd_pkt !== exp_q[0]) begin errors++; $display("FAIL fwd_pkt got %h exp %h t=%0t", fwd_pkt, exp_q[0], $time); end
            void'(exp_q.pop_front());
        end else if (!vld) begin
            checks++;
            if (fwd_pkt !== 32'h0) begin errors++; $display("FAIL empty_pkt got %h exp 0 t=%0t", fwd_pkt, $time); end
        end
        if (pkt_in_avail) begin
            if (pkt_in[27:24] >= 4'd6) exp_bad = (exp_bad == 255) ? 255 : exp_bad + 1;
            else if (exp_q.size() < 4) exp_q.push_back({4'd3, pkt_in[27:0]});
            else exp_ovf = (exp_ovf == 255) ? 255 : exp_ovf + 1;
        end
        blk = (vld && !fwd_ready) ? blk + 1 : 0;
        exp_stall = blk >= 16;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] p, input logic rdy);
        pkt_in = p; pkt_in_avail = 1; fwd_ready = rdy;
        tick();
        pkt_in_avail = 0;
    endtask

    task automatic drain();
        fwd_ready = 1; pkt_in_avail = 0;
        for (int i = 0; i < 6; i++) tick();
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (fwd_valid !== 0 || fwd_pkt !== 0 || stall !== 0 || occupancy !== 0 || drop_bad_cnt !== 0 || drop_ovf_cnt !== 0) begin
            errors++; $display("FAIL reset_outputs got v=%b p=%h s=%b o=%0d exp all zero", fwd_valid, fwd_pkt, stall, occupancy);
        end
        pkt_in = 32'h01000001; pkt_in_avail = 1;
        @(posedge clk); #1;
        pkt_in_avail = 0;
        checks++;
        if (fwd_valid !== 0) begin errors++; $display("FAIL reset_ignores_avail got %b exp 0", fwd_valid); end
        rst_b = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            pkt_in = $urandom; pkt_in_avail = 0; fwd_ready = i[0];
            tick();
        end
    endtask

    task automatic test_zero_pkt();
        send(32'h0, 1);
        checks++;
        if (fwd_valid !== 1 || fwd_pkt !== 32'h30000000) begin
            errors++; $display("FAIL zero_pkt got v=%b p=%h exp v=1 p=30000000", fwd_valid, fwd_pkt);
        end
        tick();
        tick();
    endtask

    task automatic test_bad_dest();
        send(32'h3EADBEEF, 0);
        checks++;
        if (drop_bad_cnt !== 8'd1 || fwd_valid !== 0) begin errors++; $display("FAIL bad_dest got cnt=%0d v=%b exp 1/0", drop_bad_cnt, fwd_valid); end
        send(32'h51123456, 0);
        checks++;
        if (fwd_pkt !== 32'h31123456) begin errors++; $display("FAIL src_rewrite got %h exp 31123456", fwd_pkt); end
        drain();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) send({8'h41, 24'(i + 16'hA0)}, 0);
        checks++;
        if (occupancy !== 3'd4 || drop_ovf_cnt !== 8'd1) begin errors++; $display("FAIL overflow got occ=%0d ovf=%0d exp 4/1", occupancy, drop_ovf_cnt); end
        drain();
    endtask

    task automatic test_push_pop_full_stall();
        for (int i = 0; i < 4; i++) send({8'h02, 24'(i)}, 0);
        send(32'h04ABCDEF, 1);
        checks++;
        if (occupancy !== 3'd4) begin errors++; $display("FAIL full_pushpop got occ=%0d exp 4", occupancy); end
        fwd_ready = 0;
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (stall !== 0) begin errors++; $display("FAIL stall_early got %b exp 0", stall); end
        tick();
        checks++;
        if (stall !== 1) begin errors++; $display("FAIL stall_set got %b exp 1", stall); end
        for (int i = 0; i < 20; i++) tick();
        fwd_ready = 1;
        tick();
        checks++;
        if (stall !== 0) begin errors++; $display("FAIL stall_clear got %b exp 0", stall); end
        drain();
    endtask

    task automatic test_bad_saturate();
        fwd_ready = 0;
        for (int i = 0; i < 260; i++) send(32'h0F000000 | i, 0);
        checks++;
        if (drop_bad_cnt !== 8'd255) begin errors++; $display("FAIL bad_saturate got %0d exp 255", drop_bad_cnt); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            pkt_in = $urandom & 32'hF7FFFFFF;
            pkt_in_avail = $urandom_range(0, 3) != 0;
            fwd_ready = $urandom_range(0, 2) != 0;
            tick();
        end
        drain();
    endtask

    task automatic test_reset_mid();
        fwd_ready = 0;
        for (int i = 0; i < 3; i++) send({8'h15, 24'(i)}, 0);
        #3 rst_b = 0;
        #1;
        checks++;
        if (fwd_valid !== 0 || fwd_pkt !== 0 || occupancy !== 0 || drop_bad_cnt !== 0 || drop_ovf_cnt !== 0 || stall !== 0) begin
            errors++; $display("FAIL mid_reset got v=%b p=%h o=%0d b=%0d exp zeros", fwd_valid, fwd_pkt, occupancy, drop_bad_cnt);
        end
        exp_q.delete(); exp_bad = 0; exp_ovf = 0; blk = 0; exp_stall = 0;
        #1 rst_b = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) tick();
        send(32'h05000077, 0);
        drain();
    endtask

    initial begin
        test_reset();
        test_idle();
        test_zero_pkt();
        test_bad_dest();
        test_overflow();
        test_push_pop_full_stall();
        test_back_to_back();
        test_bad_saturate();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/node_ingress.md
NODE_INGRESS -- requirements
Module: node_ingress

Interface
REQ-001 Parameter NODE_ID, 0, index (0..5) of the node this port serves.
REQ-002 Parameter NUM_NODES, 6, number of valid destination nodes.
REQ-003 Parameter DEPTH, 4, queue entries (power of 2, >=2).
REQ-004 Parameter STALL_LIMIT, 16, consecutive blocked cycles before stall is flagged.
REQ-005 clk  in  1  single clock; all state changes on posedge.
REQ-006 rst_b  in  1  asynchronous, active-low reset.
REQ-007 pkt_in  in  32  pkt_t from node: [31:28] src, [27:24] dest, [23:0] payload.
REQ-008 pkt_in_avail  in  1  pkt_in is valid this cycle; no backpressure toward the node.
REQ-009 fwd_pkt  out  32  head-of-queue packet presented to the router.
REQ-010 fwd_valid  out  1  fwd_pkt holds a packet.
REQ-011 fwd_ready  in  1  router accepts fwd_pkt this cycle.
REQ-012 occupancy  out  $clog2(DEPTH+1)  entries currently queued.
REQ-013 drop_bad_cnt  out  8  count of packets dropped for an invalid destination.
REQ-014 drop_ovf_cnt  out  8  count of packets dropped because the queue was full.
REQ-015 stall  out  1  head packet blocked for at least STALL_LIMIT cycles.

Function
REQ-016 Sample pkt_in on every posedge where pkt_in_avail=1; an all-zero pkt_in with avail=1 is a legal packet (dest 0).
REQ-017 pkt_in with avail=0 is ignored regardless of value; no entry, no counter change.
REQ-018 Drop a packet if dest >= NUM_NODES; drop_bad_cnt +1, saturating at 255.
REQ-019 Enqueue accepted packets with the src field overwritten by NODE_ID; dest and payload are unchanged.
REQ-020 Queue is FIFO; packets leave in arrival order.
REQ-021 fwd_valid = (occupancy != 0); fwd_pkt = head entry while valid, 32'h0 while empty.
REQ-022 Transfer occurs on a posedge with fwd_valid=1 and fwd_ready=1; the head is popped that edge.
REQ-023 While fwd_valid=1 and fwd_ready=0, fwd_pkt and fwd_valid hold stable.
REQ-024 Latency: a packet enqueued at edge N into an empty queue shows fwd_valid=1 in the cycle after edge N; there is no same-cycle bypass.
REQ-025 Full (occupancy=DEPTH) with no pop in the same cycle: a valid-dest packet is dropped and drop_ovf_cnt +1, saturating at 255.
REQ-026 Full with a simultaneous pop: the incoming packet is accepted; occupancy stays DEPTH.
REQ-027 Empty with pkt_in_avail=1 and fwd_ready=1: no pop occurs (fwd_valid=0); the packet is enqueued.
REQ-028 Invalid-dest and overflow conditions are exclusive; a bad-dest packet never increments drop_ovf_cnt.
REQ-029 Read and write pointers wrap modulo DEPTH; occupancy is tracked separately so full and empty are unambiguous.
REQ-030 Stall counter FSM, IDLE/WAIT/STALLED: IDLE when fwd_valid=0 or on a transfer; WAIT counts cycles with fwd_valid=1 and fwd_ready=0; WAIT goes to STALLED when the count reaches STALL_LIMIT.
REQ-031 stall=1 only in STALLED; any transfer or an empty queue returns the FSM to IDLE with the count cleared.
REQ-032 The stall counter saturates; it never wraps back to IDLE while the head stays blocked.

Reset
REQ-033 rst_b=0 immediately clears the queue, pointers, occupancy, both drop counters, and the stall FSM (IDLE, count 0).
REQ-034 During reset: fwd_valid=0, fwd_pkt=32'h0, stall=0, all counters 0; pkt_in_avail is ignored.
REQ-035 Reset asserted mid-operation discards all queued packets; no packet appears on fwd_* after release until a new one is accepted.

Verification
REQ-036 NODE_ID=2, idle 10 cycles with pkt_in=0 and avail=0 -> fwd_valid stays 0 and occupancy stays 0.
REQ-037 NODE_ID=0, pkt_in=32'h0 with avail=1 for 1 cycle and fwd_ready=1 -> fwd_valid=1 the next cycle, fwd_pkt=32'h0 for one cycle, then empty.
REQ-038 NODE_ID=3, pkt_in=32'h3EADBEEF with avail=1 -> no enqueue, drop_bad_cnt=1; then 32'h51123456 -> fwd_pkt=32'h31123456.
REQ-039 DEPTH=4, fwd_ready=0, push 5 packets with dest 1 -> occupancy=4, drop_ovf_cnt=1; fwd_ready=1 -> first four drain in order, one per cycle.
REQ-040 Full queue with push and pop in the same cycle -> occupancy stays 4 and the new packet is last out; head held with fwd_ready=0 for 16 cycles -> stall=1, cleared the cycle after the next transfer.
REQ-041 Three packets queued, rst_b pulsed low between edges -> outputs clear immediately; fwd_valid=0 after release.
